zeroriscy_wb_arbiter: RTL and testbench
=======================================

ZERORISCY_WB_ARBITER -- requirements
Module: zeroriscy_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the write-data width.
REQ-002 SHALL have parameter RV32E, default 0; when 1, register addresses SHALL be compared on bits [3:0] only.
REQ-003 SHALL have parameter DEPTH, default 2, the EX pending-FIFO entry count (legal values 1..4).
REQ-004 SHALL have port clk_int, input, 1 bit: gated core clock; reset rst_n, asynchronous, active-low.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports ex_valid_i (in, 1), ex_ready_o (out, 1), ex_waddr_i (in, 5) and ex_wdata_i (in, DATA_WIDTH): the EX writeback request.
REQ-007 SHALL have ports lsu_valid_i (in, 1), lsu_waddr_i (in, 5) and lsu_wdata_i (in, DATA_WIDTH): the load writeback, which has no ready and is always accepted.
REQ-008 SHALL have ports we_a_o (out, 1), waddr_a_o (out, 5) and wdata_a_o (out, DATA_WIDTH): the single register-file write port.
REQ-009 SHALL have ports raddr_a_i and raddr_b_i (in, 5), fwd_a_valid_o and fwd_b_valid_o (out, 1), and fwd_a_data_o and fwd_b_data_o (out, DATA_WIDTH): the forwarding lookup for writes that are still pending.
REQ-010 SHALL have port busy_o, out, 1: high while any write is pending.

Function
REQ-011 An EX transfer SHALL occur when ex_valid_i=1 and ex_ready_o=1 on a clk_int rising edge.
REQ-012 ex_ready_o SHALL be 1 exactly when FIFO count < DEPTH, and SHALL be a function of registered state only.
REQ-013 A transfer or LSU write with address 0 SHALL be accepted and then discarded: no FIFO entry and no we_a_o pulse.
REQ-014 Per-cycle selection priority SHALL be: lsu_valid_i first, then the FIFO head, then the current EX transfer (bypass).
REQ-015 EX bypass SHALL be allowed only when the FIFO is empty and lsu_valid_i=0.
REQ-016 Any non-bypassed EX transfer SHALL be pushed at the FIFO tail.
REQ-017 EX writes SHALL retire in acceptance order.
REQ-018 The selected write SHALL be registered into the output stage, so we_a_o/waddr_a_o/wdata_a_o are valid exactly 1 cycle after selection.
REQ-019 we_a_o SHALL be 1 for exactly one cycle per write.
REQ-020 When nothing is selected, we_a_o SHALL be 0 and waddr_a_o/wdata_a_o SHALL hold their previous values.
REQ-021 A FIFO push and pop in the same cycle SHALL leave count unchanged, with the popped entry being the head.
REQ-022 At full (count=DEPTH), a pop SHALL NOT allow a push in the same cycle; ex_ready_o SHALL rise on the next cycle.
REQ-023 With lsu_valid_i held high, the FIFO SHALL never drain; no starvation guard is required, since the LSU protocol bounds back-to-back loads.
REQ-024 Forwarding for raddr r≠0 SHALL search FIFO entries youngest-first, then the output stage (if we_a_o=1).
REQ-025 On the first match in that search, fwd_x_valid_o SHALL be 1 and fwd_x_data_o SHALL be that entry's data; on no match, or r=0, both SHALL be 0.
REQ-026 Forwarding outputs SHALL be combinational from the raddr inputs and registered state.
REQ-027 Forwarding SHALL NOT consider write sources present on the inputs in the current cycle.
REQ-028 busy_o SHALL equal (count≠0) OR we_a_o.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; count SHALL be held in ceil(log2(DEPTH+1)) bits.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear FIFO count and pointers, we_a_o, waddr_a_o, wdata_a_o and all FIFO data to 0.
REQ-031 During reset, ex_ready_o SHALL be 1, busy_o 0, and both fwd valids 0.
REQ-032 Reset asserted mid-operation SHALL discard all pending writes, with no we_a_o pulse after reset deassertion.
REQ-033 The first transfer SHALL be accepted on the first clk_int edge after rst_n deasserts.

Verification
REQ-034 Bypass: EX x5=0xDEADBEEF with FIFO empty and no LSU -> next cycle we_a_o=1, waddr=5, wdata=0xDEADBEEF; busy_o=1 for 1 cycle.
REQ-035 Conflict: EX x3=0x11 and LSU x7=0x22 in the same cycle -> cycle+1 writes x7=0x22, cycle+2 writes x3=0x11; fwd for raddr 3 valid=1, data 0x11 during cycle+1.
REQ-036 Full: lsu_valid_i held for 4 cycles with EX valid every cycle (DEPTH=2) -> ex_ready_o=0 after 2 accepted; after LSU drops, EX writes retire in order, ex_ready_o returns to 1.
REQ-037 x0 drop: EX x0=0xFFFFFFFF -> accepted, no we_a_o pulse, fwd for raddr 0 valid=0.
REQ-038 Forward priority: FIFO holds x9=0xA (older) and x9=0xB (younger) -> fwd_a_data_o=0xB while raddr_a_i=9.
REQ-039 Reset mid-operation: rst_n low with 2 FIFO entries pending -> count=0, we_a_o=0, and no writes after release.

Source files
------------

// File: rtl/zeroriscy_wb_arbiter.sv
// Register-file write-port arbiter between the EX writeback and the LSU load
// writeback. LSU writes always win the single write port; EX writes that cannot
// go straight through are parked in a small in-order FIFO. Pending writes are
// exposed through two forwarding lookups so readers see the newest value.
//
// Ports:
//   clk_int, rst_n                    gated core clock, async active-low reset
//   ex_valid_i/ex_ready_o             EX writeback handshake
//   ex_waddr_i/ex_wdata_i             EX write address/data
//   lsu_valid_i/lsu_waddr_i/_wdata_i  load writeback, always accepted
//   we_a_o/waddr_a_o/wdata_a_o        registered register-file write port
//   raddr_a_i/raddr_b_i               forwarding lookup addresses
//   fwd_x_valid_o/fwd_x_data_o        forwarding hit and data (combinational)
//   busy_o                            any write still pending
module zeroriscy_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          RV32E      = 1'b0,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_int,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [4:0]            ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic                  lsu_valid_i,
    input  logic [4:0]            lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  we_a_o,
    output logic [4:0]            waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    input  logic [4:0]            raddr_a_i,
    input  logic [4:0]            raddr_b_i,
    output logic                  fwd_a_valid_o,
    output logic                  fwd_b_valid_o,
    output logic [DATA_WIDTH-1:0] fwd_a_data_o,
    output logic [DATA_WIDTH-1:0] fwd_b_data_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]      count_q, count_next;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [4:0]            fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic                  ready_q, busy_q;

    logic                  ex_keep, fifo_empty, pop, push, bypass;
    logic                  sel_valid;
    logic [4:0]            sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Address helpers; RV32E only has 16 architectural registers.
    function automatic logic is_zero(input logic [4:0] a);
        return RV32E ? (a[3:0] == 4'd0) : (a == 5'd0);
    endfunction

    function automatic logic addr_eq(input logic [4:0] a, input logic [4:0] b);
        return RV32E ? (a[3:0] == b[3:0]) : (a == b);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Forwarding: youngest FIFO entry first, then the write currently on the port.
    function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [4:0] r);
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
        int unsigned           idx;
        hit  = 1'b0;
        data = '0;
        if (!is_zero(r)) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i < 32'(count_q)) begin
                    idx = 32'(rd_ptr_q) + i;
                    if (idx >= DEPTH) idx = idx - DEPTH;
                    // Later iterations are younger, so they overwrite older hits.
                    if (addr_eq(fifo_addr_q[PTR_W'(idx)], r)) begin
                        hit  = 1'b1;
                        data = fifo_data_q[PTR_W'(idx)];
                    end
                end
            end
            if (!hit && we_a_o && addr_eq(waddr_a_o, r)) begin
                hit  = 1'b1;
                data = wdata_a_o;
            end
        end
        return {hit, data};
    endfunction

    // Write-source selection: LSU, then FIFO head, then EX bypass.
    always_comb begin
        ex_keep    = ex_valid_i & ready_q & ~is_zero(ex_waddr_i);
        fifo_empty = (count_q == '0);
        pop        = ~lsu_valid_i & ~fifo_empty;
        bypass     = ~lsu_valid_i & fifo_empty & ex_keep;
        push       = ex_keep & ~bypass;
        sel_valid  = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;
        if (lsu_valid_i) begin
            sel_valid = ~is_zero(lsu_waddr_i);
            sel_addr  = lsu_waddr_i;
            sel_data  = lsu_wdata_i;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_addr  = fifo_addr_q[rd_ptr_q];
            sel_data  = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_addr  = ex_waddr_i;
            sel_data  = ex_wdata_i;
        end
    end

    // Occupancy update; a push never happens at full since ready_q is low then.
    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    // FIFO storage, pointers and the registered write port.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            we_a_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            count_q <= count_next;
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= ex_waddr_i;
                fifo_data_q[wr_ptr_q] <= ex_wdata_i;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            we_a_o <= sel_valid;
            if (sel_valid) begin
                waddr_a_o <= sel_addr;
                wdata_a_o <= sel_data;
            end
            ready_q <= (count_next < CNT_W'(DEPTH));
            busy_q  <= (count_next != '0) | sel_valid;
        end
    end

    always_comb begin
        {fwd_a_valid_o, fwd_a_data_o} = fwd_lookup(raddr_a_i);
        {fwd_b_valid_o, fwd_b_data_o} = fwd_lookup(raddr_b_i);
    end

    assign ex_ready_o = ready_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_zeroriscy_wb_arbiter.sv
module tb_zeroriscy_wb_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk_int = 1'b0;
    logic          rst_n   = 1'b0;
    logic          ex_valid_i = 1'b0;
    logic          ex_ready_o;
    logic [4:0]    ex_waddr_i = '0;
    logic [DW-1:0] ex_wdata_i = '0;
    logic          lsu_valid_i = 1'b0;
    logic [4:0]    lsu_waddr_i = '0;
    logic [DW-1:0] lsu_wdata_i = '0;
    logic          we_a_o;
    logic [4:0]    waddr_a_o;
    logic [DW-1:0] wdata_a_o;
    logic [4:0]    raddr_a_i = '0;
    logic [4:0]    raddr_b_i = '0;
    logic          fwd_a_valid_o, fwd_b_valid_o;
    logic [DW-1:0] fwd_a_data_o, fwd_b_data_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    zeroriscy_wb_arbiter #(.DATA_WIDTH(DW), .RV32E(1'b0), .DEPTH(DEPTH)) dut (
        .clk_int(clk_int), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .fwd_a_valid_o(fwd_a_valid_o), .fwd_b_valid_o(fwd_b_valid_o),
        .fwd_a_data_o(fwd_a_data_o), .fwd_b_data_o(fwd_b_data_o),
        .busy_o(busy_o)
    );

    always #5 clk_int = ~clk_int;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending EX writes as an ordered list plus the write port.
    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           q[$];
    logic          m_we    = 1'b0;
    logic [4:0]    m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;

    task automatic m_reset();
        q.delete();
        m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    task automatic m_step(input logic exv, input logic [4:0] exa, input logic [DW-1:0] exd,
                          input logic lv, input logic [4:0] la, input logic [DW-1:0] ld);
        bit  acc, sel;
        wr_t w;
        acc = exv && (q.size() < DEPTH) && (exa != 0);
        sel = 0;
        w.a = '0; w.d = '0;
        if (lv) begin
            if (la != 0) begin sel = 1; w.a = la; w.d = ld; end
            if (acc) q.push_back('{exa, exd});
        end else if (q.size() > 0) begin
            w = q.pop_front(); sel = 1;
            if (acc) q.push_back('{exa, exd});
        end else if (acc) begin
            sel = 1; w.a = exa; w.d = exd;
        end
        m_we = sel;
        if (sel) begin m_waddr = w.a; m_wdata = w.d; end
    endtask

    function automatic logic [DW:0] m_fwd(input logic [4:0] r);
        if (r == 0) return '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == r) return {1'b1, q[i].d};
        if (m_we && m_waddr == r) return {1'b1, m_wdata};
        return '0;
    endfunction

    task automatic drive(input logic exv, input logic [4:0] exa, input logic [DW-1:0] exd,
                         input logic lv, input logic [4:0] la, input logic [DW-1:0] ld);
        @(negedge clk_int);
        ex_valid_i = exv; ex_waddr_i = exa; ex_wdata_i = exd;
        lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
    endtask

    // One cycle compared entirely against the model.
    task automatic do_cycle(input logic exv, input logic [4:0] exa, input logic [DW-1:0] exd,
                            input logic lv, input logic [4:0] la, input logic [DW-1:0] ld,
                            input logic [4:0] ra, input logic [4:0] rb);
        logic [DW:0] fa, fb;
        drive(exv, exa, exd, lv, la, ld);
        @(posedge clk_int);
        m_step(exv, exa, exd, lv, la, ld);
        #1;
        raddr_a_i = ra; raddr_b_i = rb;
        #1;
        fa = m_fwd(ra); fb = m_fwd(rb);
        chk("we",       32'(we_a_o),        32'(m_we));
        chk("waddr",    32'(waddr_a_o),     32'(m_waddr));
        chk("wdata",    wdata_a_o,          m_wdata);
        chk("ready",    32'(ex_ready_o),    32'(q.size() < DEPTH));
        chk("busy",     32'(busy_o),        32'((q.size() != 0) || m_we));
        chk("fwd_a_v",  32'(fwd_a_valid_o), 32'(fa[DW]));
        chk("fwd_a_d",  fwd_a_data_o,       fa[DW-1:0]);
        chk("fwd_b_v",  32'(fwd_b_valid_o), 32'(fb[DW]));
        chk("fwd_b_d",  fwd_b_data_o,       fb[DW-1:0]);
    endtask

    typedef struct {
        logic          exv; logic [4:0] exa; logic [DW-1:0] exd;
        logic          lv;  logic [4:0] la;  logic [DW-1:0] ld;
        logic [4:0]    ra;
        logic          e_we; logic [4:0] e_waddr; logic [DW-1:0] e_wdata;
        logic          e_fv; logic [DW-1:0] e_fd;
        logic          e_ready; logic e_busy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // exv exa  exd           lv la ld    ra | we wa wd           fv fd           rdy busy
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,     5, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 1};
        tbl[1]  = '{0, 0, 0,            0, 0, 0,     5, 0, 5, 32'hDEADBEEF, 0, 0,            1, 0};
        tbl[2]  = '{1, 3, 32'h11,       1, 7, 32'h22, 3, 1, 7, 32'h22,      1, 32'h11,       1, 1};
        tbl[3]  = '{0, 0, 0,            0, 0, 0,     3, 1, 3, 32'h11,       1, 32'h11,       1, 1};
        tbl[4]  = '{0, 0, 0,            0, 0, 0,     3, 0, 3, 32'h11,       0, 0,            1, 0};
        tbl[5]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,     0, 0, 3, 32'h11,       0, 0,            1, 0};
        tbl[6]  = '{1, 9, 32'hA,        1, 1, 32'h1, 9, 1, 1, 32'h1,        1, 32'hA,        1, 1};
        tbl[7]  = '{1, 9, 32'hB,        1, 2, 32'h2, 9, 1, 2, 32'h2,        1, 32'hB,        0, 1};
        tbl[8]  = '{0, 0, 0,            0, 0, 0,     9, 1, 9, 32'hA,        1, 32'hB,        1, 1};
        tbl[9]  = '{0, 0, 0,            0, 0, 0,     9, 1, 9, 32'hB,        1, 32'hB,        1, 1};
        tbl[10] = '{0, 0, 0,            0, 0, 0,     9, 0, 9, 32'hB,        0, 0,            1, 0};

        // Values while held in reset.
        repeat (2) @(negedge clk_int);
        raddr_a_i = 5'd5; raddr_b_i = 5'd0;
        #1;
        chk("rst_ready", 32'(ex_ready_o),    32'd1);
        chk("rst_busy",  32'(busy_o),        32'd0);
        chk("rst_we",    32'(we_a_o),        32'd0);
        chk("rst_waddr", 32'(waddr_a_o),     32'd0);
        chk("rst_wdata", wdata_a_o,          32'd0);
        chk("rst_fwd_a", 32'(fwd_a_valid_o), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b_valid_o), 32'd0);
        @(posedge clk_int); #2;
        rst_n = 1'b1;
        m_reset();

        // Directed table; the first row is taken on the first edge after release.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].exv, tbl[i].exa, tbl[i].exd, tbl[i].lv, tbl[i].la, tbl[i].ld);
            @(posedge clk_int);
            m_step(tbl[i].exv, tbl[i].exa, tbl[i].exd, tbl[i].lv, tbl[i].la, tbl[i].ld);
            #1;
            raddr_a_i = tbl[i].ra; raddr_b_i = 5'd0;
            #1;
            chk($sformatf("t%0d_we", i),    32'(we_a_o),        32'(tbl[i].e_we));
            chk($sformatf("t%0d_waddr", i), 32'(waddr_a_o),     32'(tbl[i].e_waddr));
            chk($sformatf("t%0d_wdata", i), wdata_a_o,          tbl[i].e_wdata);
            chk($sformatf("t%0d_fv", i),    32'(fwd_a_valid_o), 32'(tbl[i].e_fv));
            chk($sformatf("t%0d_fd", i),    fwd_a_data_o,       tbl[i].e_fd);
            chk($sformatf("t%0d_ready", i), 32'(ex_ready_o),    32'(tbl[i].e_ready));
            chk($sformatf("t%0d_busy", i),  32'(busy_o),        32'(tbl[i].e_busy));
        end

        // LSU held four cycles with EX valid every cycle, then LSU drops.
        begin
            logic exp_rdy [5];
            exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 5; i++) begin
                do_cycle(1'b1, 5'(20 + i), 32'(100 + i), (i < 4), 5'(10 + i), 32'(i + 1), 5'd20, 5'd21);
                chk($sformatf("full_ready%0d", i), 32'(ex_ready_o), 32'(exp_rdy[i]));
            end
            chk("full_ret0", {27'd0, waddr_a_o}, 32'd20);
            do_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd21, 5'd20);
            chk("full_ret1", {27'd0, waddr_a_o}, 32'd21);
            chk("full_ret1d", wdata_a_o, 32'd101);
            do_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd21, 5'd0);
            chk("full_idle", 32'(we_a_o), 32'd0);
        end

        // Reset asserted with two pending FIFO entries.
        do_cycle(1'b1, 5'd12, 32'h12, 1'b1, 5'd4, 32'h44, 5'd12, 5'd0);
        do_cycle(1'b1, 5'd13, 32'h13, 1'b1, 5'd5, 32'h55, 5'd12, 5'd13);
        chk("pre_rst_full", 32'(ex_ready_o), 32'd0);
        @(negedge clk_int);
        ex_valid_i = 1'b0; lsu_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_ready", 32'(ex_ready_o),    32'd1);
        chk("mid_rst_busy",  32'(busy_o),        32'd0);
        chk("mid_rst_we",    32'(we_a_o),        32'd0);
        chk("mid_rst_fwd_a", 32'(fwd_a_valid_o), 32'd0);
        chk("mid_rst_fwd_b", 32'(fwd_b_valid_o), 32'd0);
        @(posedge clk_int); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            do_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd12, 5'd13);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                     ($urandom_range(0, 99) < 35), 5'($urandom_range(0, 7)), $urandom,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
